// File: rtl/pixel_stream_pkg.sv
// -----------------------------------------------------------------------------
// pixel_stream_pkg
// Shared definitions for the pixel/frame-marker stream sources.
//   - pattern-select encodings (PAT_RAMP, PAT_SOLID, PAT_CHECKER, PAT_BARS)
//   - frame generator state enum
//   - 8-entry colour-bar table, packed {R,G,B}, index 0 = leftmost bar
// -----------------------------------------------------------------------------
package pixel_stream_pkg;

    localparam logic [1:0] PAT_RAMP    = 2'd0;
    localparam logic [1:0] PAT_SOLID   = 2'd1;
    localparam logic [1:0] PAT_CHECKER = 2'd2;
    localparam logic [1:0] PAT_BARS    = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_HBLANK = 2'd2,
        ST_VBLANK = 2'd3
    } frame_state_e;

    // white, yellow, cyan, green, magenta, red, blue, black
    localparam logic [0:7][23:0] BAR_COLORS = {
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/pattern_lut.sv
// -----------------------------------------------------------------------------
// pattern_lut
// Purely combinational map from pixel coordinate and latched pattern controls
// to a pixel value. Feeds the output register of frame_pattern_gen.
// Configuration macro: FRAME_PATTERN_GEN_BARS_EN
//   defined   -> pattern 3 is eight vertical colour bars
//   undefined -> bar logic absent, pattern 3 falls back to the coordinate ramp
// Ports:
//   x, y          in   current pixel coordinate
//   pattern_sel   in   latched pattern select
//   solid_color   in   latched solid colour
//   pixel         out  pixel value {R,G,B}
// -----------------------------------------------------------------------------
module pattern_lut
    import pixel_stream_pkg::*;
#(
    parameter int WIDTH      = 320,
    parameter int DATA_WIDTH = 24,
    parameter int XW         = 9,
    parameter int YW         = 9
) (
    input  logic [XW-1:0]         x,
    input  logic [YW-1:0]         y,
    input  logic [1:0]            pattern_sel,
    input  logic [DATA_WIDTH-1:0] solid_color,
    output logic [DATA_WIDTH-1:0] pixel
);

    logic [7:0]  x_lo_s;
    logic [7:0]  y_lo_s;
    logic [23:0] ramp_s;
    logic [23:0] checker_s;
    logic [23:0] bars_s;
    logic        lut_unused_s;

    assign x_lo_s    = 8'(x);
    assign y_lo_s    = 8'(y);
    assign ramp_s    = {8'hFF, x_lo_s, y_lo_s};
    // 8x8 cells: bit 3 of each coordinate toggles every 8 pixels
    assign checker_s = (x_lo_s[3] ^ y_lo_s[3]) ? 24'hFFFFFF : 24'h000000;
    // upper coordinate bits only matter to the bar compare chain
    assign lut_unused_s = ^{x, y};

`ifdef FRAME_PATTERN_GEN_BARS_EN
    logic [2:0] bar_idx_s;

    // Bar index = x*8/WIDTH as a count of constant thresholds ceil(k*WIDTH/8) passed
    always_comb begin
        bar_idx_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            if (int'(x) >= ((k * WIDTH) + 7) / 8) begin
                bar_idx_s = bar_idx_s + 3'd1;
            end else begin
                bar_idx_s = bar_idx_s;
            end
        end
    end

    assign bars_s = BAR_COLORS[bar_idx_s];
`else
    assign bars_s = ramp_s;
`endif

    // Pattern select mux
    always_comb begin
        case (pattern_sel)
            PAT_RAMP:    pixel = DATA_WIDTH'(ramp_s);
            PAT_SOLID:   pixel = solid_color;
            PAT_CHECKER: pixel = DATA_WIDTH'(checker_s);
            PAT_BARS:    pixel = DATA_WIDTH'(bars_s);
            default:     pixel = DATA_WIDTH'(ramp_s);
        endcase
    end

endmodule

// File: rtl/frame_pattern_gen.sv
// -----------------------------------------------------------------------------
// frame_pattern_gen
// Streaming test-pattern frame source (transmit end of the pixel/frame-marker
// interface). Walks x/y over WIDTH x HEIGHT active pixels, inserting HBLANK idle
// cycles after each line and VBLANK idle cycles after each frame.
// Configuration macro: FRAME_PATTERN_GEN_BARS_EN (colour bars, see pattern_lut)
// Ports:
//   clk, rst_n    clock, async active-low reset
//   start         begin one frame (sampled only in IDLE)
//   continuous    at end of VBLANK, start the next frame automatically
//   pattern_sel   0 ramp, 1 solid, 2 checkerboard, 3 colour bars
//   solid_color   colour for pattern 1
//   pixel_out     pixel data (zero while pixel_valid is low)
//   pixel_valid   pixel_out qualifier
//   frame_start   pulse with pixel (0,0)
//   frame_end     pulse with pixel (WIDTH-1,HEIGHT-1)
//   busy          high whenever not idle
// All outputs are registered; they trail the state/counters by one cycle.
// -----------------------------------------------------------------------------
module frame_pattern_gen
    import pixel_stream_pkg::*;
#(
    parameter int WIDTH      = 320,
    parameter int HEIGHT     = 466,
    parameter int DATA_WIDTH = 24,
    parameter int HBLANK     = 0,
    parameter int VBLANK     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  continuous,
    input  logic [1:0]            pattern_sel,
    input  logic [DATA_WIDTH-1:0] solid_color,
    output logic [DATA_WIDTH-1:0] pixel_out,
    output logic                  pixel_valid,
    output logic                  frame_start,
    output logic                  frame_end,
    output logic                  busy
);

    localparam int XW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW        = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int BLANK_MAX = (HBLANK > VBLANK) ? HBLANK : VBLANK;
    localparam int BW        = (BLANK_MAX > 1) ? $clog2(BLANK_MAX) : 1;

    localparam logic [XW-1:0] X_LAST  = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(HEIGHT - 1);
    localparam logic [BW-1:0] HB_LAST = BW'((HBLANK > 0) ? HBLANK - 1 : 0);
    localparam logic [BW-1:0] VB_LAST = BW'((VBLANK > 0) ? VBLANK - 1 : 0);

    frame_state_e            state_r, state_next_s, eof_state_s;
    logic [XW-1:0]           x_r, x_next_s;
    logic [YW-1:0]           y_r, y_next_s;
    logic [BW-1:0]           blank_r, blank_next_s;
    logic                    new_frame_s, eof_restart_s;
    logic [1:0]              pat_r;
    logic [DATA_WIDTH-1:0]   solid_r;
    logic [DATA_WIDTH-1:0]   lut_pixel_s;
    logic                    active_s, first_s, last_s;

    logic [DATA_WIDTH-1:0]   pixel_out_r;
    logic                    pixel_valid_r, frame_start_r, frame_end_r, busy_r;

    assign active_s = (state_r == ST_ACTIVE);
    assign first_s  = active_s && (x_r == '0) && (y_r == '0);
    assign last_s   = active_s && (x_r == X_LAST) && (y_r == Y_LAST);

    // Destination once the last line (and its HBLANK) is finished; skips VBLANK when it is zero
    always_comb begin
        if (VBLANK > 0) begin
            eof_state_s   = ST_VBLANK;
            eof_restart_s = 1'b0;
        end else if (continuous) begin
            eof_state_s   = ST_ACTIVE;
            eof_restart_s = 1'b1;
        end else begin
            eof_state_s   = ST_IDLE;
            eof_restart_s = 1'b0;
        end
    end

    // Next-state and counter update
    always_comb begin
        state_next_s = state_r;
        x_next_s     = x_r;
        y_next_s     = y_r;
        blank_next_s = blank_r;
        new_frame_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_next_s = ST_ACTIVE;
                    x_next_s     = '0;
                    y_next_s     = '0;
                    new_frame_s  = 1'b1;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (x_r == X_LAST) begin
                    x_next_s = '0;
                    if (HBLANK > 0) begin
                        state_next_s = ST_HBLANK;
                        blank_next_s = '0;
                    end else if (y_r == Y_LAST) begin
                        y_next_s     = '0;
                        blank_next_s = '0;
                        state_next_s = eof_state_s;
                        new_frame_s  = eof_restart_s;
                    end else begin
                        y_next_s = y_r + YW'(1);
                    end
                end else begin
                    x_next_s = x_r + XW'(1);
                end
            end
            ST_HBLANK: begin
                if (blank_r == HB_LAST) begin
                    blank_next_s = '0;
                    if (y_r == Y_LAST) begin
                        y_next_s     = '0;
                        state_next_s = eof_state_s;
                        new_frame_s  = eof_restart_s;
                    end else begin
                        y_next_s     = y_r + YW'(1);
                        state_next_s = ST_ACTIVE;
                    end
                end else begin
                    blank_next_s = blank_r + BW'(1);
                end
            end
            ST_VBLANK: begin
                if (blank_r == VB_LAST) begin
                    blank_next_s = '0;
                    if (continuous) begin
                        state_next_s = ST_ACTIVE;
                        new_frame_s  = 1'b1;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    blank_next_s = blank_r + BW'(1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, counter and frame-latched pattern registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            x_r     <= '0;
            y_r     <= '0;
            blank_r <= '0;
            pat_r   <= PAT_RAMP;
            solid_r <= '0;
        end else begin
            state_r <= state_next_s;
            x_r     <= x_next_s;
            y_r     <= y_next_s;
            blank_r <= blank_next_s;
            if (new_frame_s) begin
                pat_r   <= pattern_sel;
                solid_r <= solid_color;
            end else begin
                pat_r   <= pat_r;
                solid_r <= solid_r;
            end
        end
    end

    pattern_lut #(
        .WIDTH      (WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .XW         (XW),
        .YW         (YW)
    ) u_lut (
        .x           (x_r),
        .y           (y_r),
        .pattern_sel (pat_r),
        .solid_color (solid_r),
        .pixel       (lut_pixel_s)
    );

    // Output register stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pixel_out_r   <= '0;
            pixel_valid_r <= 1'b0;
            frame_start_r <= 1'b0;
            frame_end_r   <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            pixel_out_r   <= active_s ? lut_pixel_s : '0;
            pixel_valid_r <= active_s;
            frame_start_r <= first_s;
            frame_end_r   <= last_s;
            busy_r        <= (state_r != ST_IDLE);
        end
    end

    assign pixel_out   = pixel_out_r;
    assign pixel_valid = pixel_valid_r;
    assign frame_start = frame_start_r;
    assign frame_end   = frame_end_r;
    assign busy        = busy_r;

endmodule

// File: tb/tb_frame_pattern_gen.sv
// -----------------------------------------------------------------------------
// tb_frame_pattern_gen
// Two generator instances share one set of inputs:
//   A: 4x3, HBLANK=0, VBLANK=2      B: 320x3, HBLANK=2, VBLANK=2
// A reference model per instance tracks the position inside the frame period
// and derives every output cycle arithmetically (line = k/(W+HB), etc.).
// Directed phases cover the listed scenarios, then random stimulus runs.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_frame_pattern_gen;

    localparam int AW = 4,   AH = 3, AHB = 0, AVB = 2;
    localparam int BWD = 320, BH = 3, BHB = 2, BVB = 2;
    localparam int A_PERIOD = AH * (AW + AHB) + AVB;
    localparam int B_PERIOD = BH * (BWD + BHB) + BVB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic [23:0] solid_color = 24'h000000;

    logic [23:0] pix_a, pix_b;
    logic        valid_a, fs_a, fe_a, busy_a;
    logic        valid_b, fs_b, fe_b, busy_b;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    frame_pattern_gen #(.WIDTH(AW), .HEIGHT(AH), .DATA_WIDTH(24), .HBLANK(AHB), .VBLANK(AVB)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .pattern_sel(pattern_sel), .solid_color(solid_color),
        .pixel_out(pix_a), .pixel_valid(valid_a), .frame_start(fs_a),
        .frame_end(fe_a), .busy(busy_a)
    );

    frame_pattern_gen #(.WIDTH(BWD), .HEIGHT(BH), .DATA_WIDTH(24), .HBLANK(BHB), .VBLANK(BVB)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
        .pattern_sel(pattern_sel), .solid_color(solid_color),
        .pixel_out(pix_b), .pixel_valid(valid_b), .frame_start(fs_b),
        .frame_end(fe_b), .busy(busy_b)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [23:0] bar_color(input int idx);
        case (idx)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] ref_pixel(input int w, input int x, input int y,
                                              input logic [1:0] pat, input logic [23:0] sol);
        logic [23:0] ramp;
        ramp = {8'hFF, 8'(x % 256), 8'(y % 256)};
        case (pat)
            2'd1: return sol;
            2'd2: return (((x / 8) % 2) != ((y / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
`ifdef FRAME_PATTERN_GEN_BARS_EN
            2'd3: return bar_color((x * 8) / w);
`else
            2'd3: return ramp;
`endif
            default: return ramp;
        endcase
    endfunction

    // Expected {busy, frame_end, frame_start, valid, pixel} for cycle k of a frame period
    function automatic logic [27:0] exp_entry(input int w, input int h, input int hb, input int k,
                                              input logic [1:0] pat, input logic [23:0] sol);
        int line_len;
        int line;
        int col;
        line_len = w + hb;
        line     = k / line_len;
        col      = k % line_len;
        if (k >= h * line_len || col >= w) return {1'b1, 3'b000, 24'h000000};
        return {1'b1, (k == (h - 1) * line_len + w - 1), (k == 0), 1'b1,
                ref_pixel(w, col, line, pat, sol)};
    endfunction

    int          pos_a = -1, pos_b = -1;
    logic [1:0]  mpat_a, mpat_b;
    logic [23:0] msol_a, msol_b;
    logic [27:0] cur_a = 28'h0, cur_b = 28'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_a <= -1;
            cur_a <= 28'h0;
        end else if (pos_a < 0) begin
            cur_a <= 28'h0;
            if (start) begin
                pos_a <= 0; mpat_a <= pattern_sel; msol_a <= solid_color;
            end
        end else begin
            cur_a <= exp_entry(AW, AH, AHB, pos_a, mpat_a, msol_a);
            if (pos_a == A_PERIOD - 1) begin
                if (continuous) begin
                    pos_a <= 0; mpat_a <= pattern_sel; msol_a <= solid_color;
                end else begin
                    pos_a <= -1;
                end
            end else begin
                pos_a <= pos_a + 1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_b <= -1;
            cur_b <= 28'h0;
        end else if (pos_b < 0) begin
            cur_b <= 28'h0;
            if (start) begin
                pos_b <= 0; mpat_b <= pattern_sel; msol_b <= solid_color;
            end
        end else begin
            cur_b <= exp_entry(BWD, BH, BHB, pos_b, mpat_b, msol_b);
            if (pos_b == B_PERIOD - 1) begin
                if (continuous) begin
                    pos_b <= 0; mpat_b <= pattern_sel; msol_b <= solid_color;
                end else begin
                    pos_b <= -1;
                end
            end else begin
                pos_b <= pos_b + 1;
            end
        end
    end

    // Cycle-by-cycle stream comparison, sampled on the inactive edge
    always @(negedge clk) begin
        check_val("stream_a", {busy_a, fe_a, fs_a, valid_a, pix_a}, cur_a);
        check_val("stream_b", {busy_b, fe_b, fs_b, valid_b, pix_b}, cur_b);
    end

    // ---------------- directed helpers ----------------
    function automatic logic flag(input int sel);
        case (sel)
            0: return fs_a;
            1: return fe_a;
            2: return fs_b;
            3: return fe_b;
            default: return (!busy_a && !busy_b);
        endcase
    endfunction

    task automatic wait_for(input int sel, input int bound, output int cycles);
        cycles = 0;
        while (!flag(sel) && cycles < bound) begin
            @(negedge clk);
            cycles++;
        end
        check_val($sformatf("wait_sel%0d", sel), flag(sel), 1'b1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    int cyc;
    int vcnt;
    int span;

    initial begin
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("reset_a", {busy_a, fe_a, fs_a, valid_a, pix_a}, 28'h0);
        check_val("reset_b", {busy_b, fe_b, fs_b, valid_b, pix_b}, 28'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- single frame, ramp, A geometry ----
        pattern_sel = 2'd0;
        pulse_start();
        wait_for(0, 10, cyc);
        check_val("a_first_pix", pix_a, 24'hFF0000);
        vcnt = 0;
        for (int i = 0; i < 12; i++) begin
            vcnt += int'(valid_a);
            if (i < 11) @(negedge clk);
        end
        check_val("a_fe_cycle12", fe_a, 1'b1);
        check_val("a_last_pix", pix_a, 24'hFF0302);
        check_val("a_valid_count", vcnt, 12);
        @(negedge clk);
        @(negedge clk);
        check_val("a_busy_vblank", busy_a, 1'b1);
        @(negedge clk);
        check_val("a_busy_low", busy_a, 1'b0);
        wait_for(4, 3000, cyc);

        // ---- bars / HBLANK on B geometry ----
        pattern_sel = 2'd3;
        pulse_start();
        wait_for(2, 10, cyc);
        span = 1;
        while (!fe_b && span < 2000) begin
`ifdef FRAME_PATTERN_GEN_BARS_EN
            if (span == 1)   check_val("bars_x0",   pix_b, 24'hFFFFFF);
            if (span == 41)  check_val("bars_x40",  pix_b, 24'hFFFF00);
            if (span == 320) check_val("bars_x319", pix_b, 24'h000000);
            if (span == 323) check_val("bars_l1x0", pix_b, 24'hFFFFFF);
`else
            if (span == 1)   check_val("bars_x0",   pix_b, 24'hFF0000);
            if (span == 41)  check_val("bars_x40",  pix_b, 24'hFF2800);
            if (span == 320) check_val("bars_x319", pix_b, 24'hFF3F00);
            if (span == 323) check_val("bars_l1x0", pix_b, 24'hFF0001);
`endif
            if (span == 321 || span == 322) check_val("hblank_gap", valid_b, 1'b0);
            @(negedge clk);
            span++;
        end
        check_val("b_span", span, 964);
        wait_for(4, 3000, cyc);

        // ---- continuous mode, mid-frame pattern change ----
        continuous = 1'b1;
        pattern_sel = 2'd0;
        pulse_start();
        wait_for(0, 10, cyc);
        pattern_sel = 2'd1;
        solid_color = 24'h123456;
        wait_for(1, 20, cyc);
        check_val("cont_f1_last", pix_a, 24'hFF0302);
        wait_for(0, 10, cyc);
        check_val("cont_gap", cyc, 3);
        check_val("cont_f2_pix", pix_a, 24'h123456);
        continuous = 1'b0;
        wait_for(4, 3000, cyc);

        // ---- random stimulus ----
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 31) == 0);
            if ($urandom_range(0, 15) == 0) pattern_sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) solid_color = 24'($urandom);
            continuous = ($urandom_range(0, 3) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        continuous = 1'b0;
        wait_for(4, 3000, cyc);

        // ---- reset in the middle of a frame at pixel (2,1) ----
        pattern_sel = 2'd0;
        pulse_start();
        wait_for(0, 10, cyc);
        repeat (6) @(negedge clk);
        check_val("pre_reset_pix", {valid_a, pix_a}, {1'b1, 24'hFF0201});
        #1 rst_n = 1'b0;
        #1;
        check_val("async_clr_a", {busy_a, fe_a, fs_a, valid_a, pix_a}, 28'h0);
        check_val("async_clr_b", {busy_b, fe_b, fs_b, valid_b, pix_b}, 28'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---- fresh frame, start pulsed while active must be ignored ----
        pulse_start();
        wait_for(0, 10, cyc);
        check_val("fresh_first", pix_a, 24'hFF0000);
        vcnt = 0;
        span = 0;
        while (!fe_a && span < 50) begin
            vcnt += int'(valid_a);
            start = (span == 4);
            @(negedge clk);
            span++;
        end
        start = 1'b0;
        vcnt += int'(valid_a);
        check_val("ignored_start_cnt", vcnt, 12);
        wait_for(4, 3000, cyc);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
